rat_recovery_ctrl: RTL
======================

# rat_recovery_ctrl

Sequencer that rolls the register alias table back after a pipeline flush. On a branch-mispredict flush it walks the squashed ROB entries from newest to oldest, issuing one restore-map operation per cycle (new physical ID freed, old physical ID revived). On an exception-style flush it issues a single full-table restore from the committed valid/visible snapshot. It sits between the commit stage and the RAT, and holds rename stalled via `busy` for the whole recovery.

## Interface
- `PHY_REG_NUM`, default 64: physical register count; width of the snapshot vectors.
- `PHY_REG_ID_WIDTH`, default 6: physical register ID width.
- `ROB_ID_WIDTH`, default 5: ROB index width; ROB depth is 2^ROB_ID_WIDTH.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `flush_req`  in  1  partial-rollback request, single-cycle pulse.
- `flush_rob_id`  in  ROB_ID_WIDTH  oldest squashed ROB entry.
- `rob_tail_id`  in  ROB_ID_WIDTH  ROB tail (next free slot) at request time.
- `rob_full`  in  1  ROB full at request time.
- `full_restore_req`  in  1  full-table restore request, single-cycle pulse.
- `snap_valid`  in  PHY_REG_NUM  committed map-valid snapshot.
- `snap_visible`  in  PHY_REG_NUM  committed map-visible snapshot.
- `ctrl_rob_read_id`  out  ROB_ID_WIDTH  ROB entry being walked.
- `rob_ctrl_has_dest`  in  1  walked entry writes a destination register.
- `rob_ctrl_new_phy_id`  in  PHY_REG_ID_WIDTH  walked entry's new physical ID.
- `rob_ctrl_old_phy_id`  in  PHY_REG_ID_WIDTH  walked entry's previous physical ID.
- `restore_map`  out  1  RAT single-entry restore strobe.
- `restore_new_phy_id`, `restore_old_phy_id`  out  PHY_REG_ID_WIDTH  restore operands.
- `map_table_restore`  out  1  RAT full-vector restore strobe.
- `map_table_valid`, `map_table_visible`  out  PHY_REG_NUM  latched snapshot.
- `busy`  out  1  recovery in progress; rename must not map.
- `done`  out  1  single-cycle completion pulse.

## Operation
- States: IDLE, WALK, FULL, DONE.
- IDLE, `full_restore_req`=1: latch `snap_valid` and `snap_visible`, then go to FULL. This takes priority over a simultaneous `flush_req`, which is dropped.
- IDLE, `flush_req`=1 only: compute N = (rob_tail_id − flush_rob_id) mod 2^ROB_ID_WIDTH.
  - If N=0 and `rob_full`=1, N = 2^ROB_ID_WIDTH.
  - If N=0 and `rob_full`=0, go directly to DONE.
  - Otherwise load ptr = rob_tail_id − 1 (wrapping), load cnt = N (ROB_ID_WIDTH+1 bits), and go to WALK.
- WALK, each cycle:
  - `ctrl_rob_read_id` = ptr; the ROB read is combinational, same cycle.
  - `restore_map` = `rob_ctrl_has_dest`; `restore_new_phy_id`/`restore_old_phy_id` = ROB data.
  - ptr decrements with wrap (0 → 2^ROB_ID_WIDTH−1); cnt decrements.
  - When cnt==1 this is the last entry; go to DONE.
- FULL: `map_table_restore`=1 for exactly one cycle with the latched vectors, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `busy` = (state != IDLE).
- Requests arriving while not in IDLE are ignored; upstream does not issue them.
- Outside WALK, `restore_map`=0 and the restore IDs are 0. Outside FULL, `map_table_restore`=0.
- `ctrl_rob_read_id` = ptr in every state.

## Timing
- Reset values:
  - state IDLE, ptr 0, cnt 0.
  - All outputs 0, including the snapshot vectors, `busy`, and `done`.
- Reset mid-WALK or mid-FULL: return to IDLE next edge with no further strobes and no `done`.
- Request accepted at edge E0. The first WALK or FULL cycle is E0+1.
- Partial flush with N entries:
  - `restore_map` slots occupy cycles E0+1 .. E0+N.
  - `done` asserts at E0+N+1.
  - `busy` is high from E0+1 through E0+N+1.
- N=0: `done` asserts at E0+1 and no restore is issued.
- Full restore: `map_table_restore` at E0+1, `done` at E0+2.
- Entries with `has_dest`=0 still consume one cycle.
- Walk order is strictly newest to oldest. The RAT relies on this when the same architectural register has several squashed mappings.

## Test plan
- Reset, then idle 5 cycles -> all outputs 0, `busy`=0.
- tail=10, flush_id=7, all has_dest=1 -> read ids 9, 8, 7 on three consecutive cycles, each with `restore_map`=1 and the matching phy IDs; `done` on the 4th cycle; `busy` high for 4 cycles.
- tail=2, flush_id=30 (depth 32), entry 0 has has_dest=0 -> read ids 1, 0, 31, 30; `restore_map` pattern 1, 0, 1, 1; `done` on the 5th cycle.
- tail=flush_id=5: with rob_full=0 -> `done` next cycle and no strobes; with rob_full=1 -> 32 walk cycles, read ids 4 down to 5 with wrap.
- `full_restore_req` and `flush_req` asserted together, snap_valid=0x...FFFE -> one `map_table_restore` cycle carrying that vector, no `restore_map`, `done` one cycle later.
- `rst` asserted on the 2nd WALK cycle of a 6-entry flush -> IDLE next cycle, no further `restore_map`, no `done`.

Source files
------------

// File: rtl/rat_recovery_ctrl_if.sv
// Bundle of signals between the recovery sequencer (slave), its requesters,
// the ROB read port and the RAT restore ports (master side).
interface rat_recovery_ctrl_if #(
  parameter int PHY_REG_NUM      = 64,
  parameter int PHY_REG_ID_WIDTH = 6,
  parameter int ROB_ID_WIDTH     = 5
);
  logic                        flush_req;
  logic [ROB_ID_WIDTH-1:0]     flush_rob_id;
  logic [ROB_ID_WIDTH-1:0]     rob_tail_id;
  logic                        rob_full;
  logic                        full_restore_req;
  logic [PHY_REG_NUM-1:0]      snap_valid;
  logic [PHY_REG_NUM-1:0]      snap_visible;
  logic [ROB_ID_WIDTH-1:0]     ctrl_rob_read_id;
  logic                        rob_ctrl_has_dest;
  logic [PHY_REG_ID_WIDTH-1:0] rob_ctrl_new_phy_id;
  logic [PHY_REG_ID_WIDTH-1:0] rob_ctrl_old_phy_id;
  logic                        restore_map;
  logic [PHY_REG_ID_WIDTH-1:0] restore_new_phy_id;
  logic [PHY_REG_ID_WIDTH-1:0] restore_old_phy_id;
  logic                        map_table_restore;
  logic [PHY_REG_NUM-1:0]      map_table_valid;
  logic [PHY_REG_NUM-1:0]      map_table_visible;
  logic                        busy;
  logic                        done;

  modport master (
    output flush_req, flush_rob_id, rob_tail_id, rob_full, full_restore_req,
           snap_valid, snap_visible, rob_ctrl_has_dest, rob_ctrl_new_phy_id,
           rob_ctrl_old_phy_id,
    input  ctrl_rob_read_id, restore_map, restore_new_phy_id, restore_old_phy_id,
           map_table_restore, map_table_valid, map_table_visible, busy, done
  );

  modport slave (
    input  flush_req, flush_rob_id, rob_tail_id, rob_full, full_restore_req,
           snap_valid, snap_visible, rob_ctrl_has_dest, rob_ctrl_new_phy_id,
           rob_ctrl_old_phy_id,
    output ctrl_rob_read_id, restore_map, restore_new_phy_id, restore_old_phy_id,
           map_table_restore, map_table_valid, map_table_visible, busy, done
  );
endinterface

// File: rtl/rat_recovery_ctrl.sv
// RAT rollback sequencer: walks squashed ROB entries newest-to-oldest issuing
// per-entry restores, or issues one full-table restore from the committed snapshot.
module rat_recovery_ctrl #(
  parameter int PHY_REG_NUM      = 64,
  parameter int PHY_REG_ID_WIDTH = 6,
  parameter int ROB_ID_WIDTH     = 5
) (
  input logic                clk,
  input logic                rst,
  rat_recovery_ctrl_if.slave bus
);
  localparam logic [ROB_ID_WIDTH-1:0] PTR_ONE   = ROB_ID_WIDTH'(1);
  localparam logic [ROB_ID_WIDTH:0]   CNT_ONE   = (ROB_ID_WIDTH + 1)'(1);
  localparam logic [ROB_ID_WIDTH:0]   ROB_DEPTH = {1'b1, {ROB_ID_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    FULL,
    DONE
  } state_t;

  state_t                  state, state_next;
  logic [ROB_ID_WIDTH-1:0] ptr, ptr_next;
  logic [ROB_ID_WIDTH:0]   cnt, cnt_next;
  logic [PHY_REG_NUM-1:0]  snap_valid_q, snap_valid_next;
  logic [PHY_REG_NUM-1:0]  snap_visible_q, snap_visible_next;
  logic [ROB_ID_WIDTH-1:0] flush_dist;

  assign flush_dist = bus.rob_tail_id - bus.flush_rob_id;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      cnt            <= '0;
      snap_valid_q   <= '0;
      snap_visible_q <= '0;
    end else begin
      state          <= state_next;
      ptr            <= ptr_next;
      cnt            <= cnt_next;
      snap_valid_q   <= snap_valid_next;
      snap_visible_q <= snap_visible_next;
    end
  end

  // NOTE: every variable gets a hold/idle default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next         = state;
    ptr_next           = ptr;
    cnt_next           = cnt;
    snap_valid_next    = snap_valid_q;
    snap_visible_next  = snap_visible_q;
    bus.restore_map        = 1'b0;
    bus.restore_new_phy_id = '0;
    bus.restore_old_phy_id = '0;
    bus.map_table_restore  = 1'b0;
    bus.done               = 1'b0;

    unique case (state)
      IDLE: begin
        // Full restore wins; a coincident partial flush is dropped.
        if (bus.full_restore_req) begin
          snap_valid_next   = bus.snap_valid;
          snap_visible_next = bus.snap_visible;
          state_next        = FULL;
        end else if (bus.flush_req) begin
          if (flush_dist == '0 && !bus.rob_full) begin
            state_next = DONE;
          end else begin
            ptr_next   = bus.rob_tail_id - PTR_ONE;
            cnt_next   = (flush_dist == '0) ? ROB_DEPTH : {1'b0, flush_dist};
            state_next = WALK;
          end
        end
      end
      WALK: begin
        bus.restore_map        = bus.rob_ctrl_has_dest;
        bus.restore_new_phy_id = bus.rob_ctrl_new_phy_id;
        bus.restore_old_phy_id = bus.rob_ctrl_old_phy_id;
        ptr_next               = ptr - PTR_ONE;
        cnt_next               = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_next = DONE;
      end
      FULL: begin
        bus.map_table_restore = 1'b1;
        state_next            = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.ctrl_rob_read_id  = ptr;
  assign bus.map_table_valid   = snap_valid_q;
  assign bus.map_table_visible = snap_visible_q;
  assign bus.busy              = (state != IDLE);
endmodule
